// File: rtl/system_trace_pkg.sv
// Shared types and sizing for the system_trace block.
// SYSTEM_TRACE_TIMESTAMP_EN appends a TS_W-bit cycle stamp as the LSB field of each entry.
package system_trace_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPost  = 2'd2,
        StDone  = 2'd3
    } trace_state_e;

    localparam int unsigned TS_W          = 32;
    localparam int unsigned NUM_REGS_DFLT = 8;
    localparam int unsigned REG_W_DFLT    = 16;

    function automatic int unsigned entry_w(input int unsigned num_regs,
                                            input int unsigned reg_w);
        int unsigned w;
        w = num_regs * reg_w + 3 * reg_w;
`ifdef SYSTEM_TRACE_TIMESTAMP_EN
        w += TS_W;
`endif
        return w;
    endfunction

    // Entry layout for the default configuration, MSB first.
    typedef struct packed {
        logic [NUM_REGS_DFLT*REG_W_DFLT-1:0] gprc;
        logic [REG_W_DFLT-1:0]               psw;
        logic [REG_W_DFLT-1:0]               pc;
        logic [REG_W_DFLT-1:0]               inst;
`ifdef SYSTEM_TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]                     ts;
`endif
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port, no reset.
module trace_ram #(
    parameter int unsigned WIDTH = 176,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/system_trace.sv
// Rolling trace of retired CPU state, frozen a set number of samples after a trigger.
// Optional SYSTEM_TRACE_TIMESTAMP_EN adds a free-running cycle stamp to each entry.
module system_trace
    import system_trace_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned REG_W     = 16,
    parameter int unsigned POST_TRIG = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REGS*REG_W-1:0]         gprc,
    input  logic [REG_W-1:0]                  psw,
    input  logic [REG_W-1:0]                  pc,
    input  logic [REG_W-1:0]                  inst,
    input  logic                              sample,
    input  logic                              arm,
    input  logic                              force_trig,
    input  logic                              trig_en,
    input  logic [REG_W-1:0]                  trig_pc,
    input  logic                              rd_en,
    input  logic [$clog2(DEPTH)-1:0]          rd_addr,
    output logic [entry_w(NUM_REGS, REG_W)-1:0] rd_data,
    output logic                              rd_valid,
    output logic [1:0]                        state,
    output logic [$clog2(DEPTH):0]            count,
    output logic                              done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = entry_w(NUM_REGS, REG_W);

    trace_state_e  state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] post_q, post_d;
    logic          hit;
    logic          we;
    logic [AW-1:0] waddr;
    logic [EW-1:0] wdata;
    logic [AW-1:0] oldest;
    logic [AW-1:0] raddr;
    logic          in_range;
    logic          re;
    logic [EW-1:0] ram_rdata;
    logic          rd_valid_q;
    logic          rd_zero_q;

    assign hit = force_trig | (trig_en & sample & (pc == trig_pc));

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        post_d  = post_q;
        we      = 1'b0;
        waddr   = wptr_q;
        if (arm) begin
            // Capture restarts on this cycle: a coincident sample becomes entry 0, a hit is dropped.
            state_d = StArmed;
            waddr   = '0;
            we      = sample;
            wptr_d  = sample ? AW'(1) : '0;
            count_d = sample ? CW'(1) : '0;
        end else begin
            unique case (state_q)
                StArmed, StPost: begin
                    if (sample) begin
                        we      = 1'b1;
                        wptr_d  = wptr_q + AW'(1);
                        count_d = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
                    end
                    if (state_q == StArmed) begin
                        if (hit) begin
                            post_d  = CW'(POST_TRIG);
                            state_d = (POST_TRIG == 0) ? StDone : StPost;
                        end
                    end else if (sample) begin
                        post_d = post_q - CW'(1);
                        if (post_q == CW'(1)) begin
                            state_d = StDone;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            count_q <= '0;
            post_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            post_q  <= post_d;
        end
    end

`ifdef SYSTEM_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (rst || arm) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign wdata = {gprc, psw, pc, inst, ts_q};
`else
    assign wdata = {gprc, psw, pc, inst};
`endif

    // Once the buffer has wrapped, the oldest entry sits at the write pointer.
    assign oldest   = (count_q == CW'(DEPTH)) ? wptr_q : '0;
    assign raddr    = oldest + rd_addr;
    assign in_range = {1'b0, rd_addr} < count_q;
    assign re       = rd_en & (state_q == StDone) & in_range;

    trace_ram #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .re   (re),
        .raddr(raddr),
        .rdata(ram_rdata)
    );

    // RAM output only changes on an in-range read, so rd_data holds without an extra copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            rd_valid_q <= rd_en & (state_q == StDone);
            if (rd_en && (state_q == StDone)) begin
                rd_zero_q <= ~in_range;
            end
        end
    end

    assign rd_data  = rd_zero_q ? '0 : ram_rdata;
    assign rd_valid = rd_valid_q;
    assign state    = state_q;
    assign count    = count_q;
    assign done     = (state_q == StDone);

endmodule

// File: tb/tb_system_trace.sv
// Self-checking bench for system_trace: directed scenarios plus random traffic,
// read data checked by a scoreboard against a queue-based history model.
module tb_system_trace;
    import system_trace_pkg::*;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned NUM_REGS  = 8;
    localparam int unsigned REG_W     = 16;
    localparam int unsigned POST_TRIG = 2;
    localparam int unsigned EW        = $bits(trace_entry_t);

    logic                      clk;
    logic                      rst;
    logic [NUM_REGS*REG_W-1:0] gprc;
    logic [REG_W-1:0]          psw;
    logic [REG_W-1:0]          pc;
    logic [REG_W-1:0]          inst;
    logic                      sample;
    logic                      arm;
    logic                      force_trig;
    logic                      trig_en;
    logic [REG_W-1:0]          trig_pc;
    logic                      rd_en;
    logic [2:0]                rd_addr;
    logic [EW-1:0]             rd_data;
    logic                      rd_valid;
    logic [1:0]                state;
    logic [3:0]                count;
    logic                      done;

    system_trace #(
        .DEPTH    (DEPTH),
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W),
        .POST_TRIG(POST_TRIG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gprc      (gprc),
        .psw       (psw),
        .pc        (pc),
        .inst      (inst),
        .sample    (sample),
        .arm       (arm),
        .force_trig(force_trig),
        .trig_en   (trig_en),
        .trig_pc   (trig_pc),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .state     (state),
        .count     (count),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: captured history oldest-first, phase 0..3, samples left after trigger.
    trace_entry_t hist[$];
    trace_entry_t exp_q[$];
    int           mstate = 0;
    int           mpost  = 0;
`ifdef SYSTEM_TRACE_TIMESTAMP_EN
    logic [31:0]  mts = '0;
`endif
    trace_entry_t mon_exp;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rd_valid_unexpected", 256'(rd_valid), 256'(0));
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_data", 256'(rd_data), 256'(mon_exp));
            end
        end
    end

    task automatic push_hist(input trace_entry_t e);
        hist.push_back(e);
        if (hist.size() > DEPTH) void'(hist.pop_front());
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; arm = 1'b0; sample = 1'b0; force_trig = 1'b0;
        trig_en = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (n) @(posedge clk);
        #1;
        mstate = 0;
        hist.delete();
`ifdef SYSTEM_TRACE_TIMESTAMP_EN
        mts = '0;
`endif
        check("rst_state", 256'(state), 256'(0));
        check("rst_count", 256'(count), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_rd_valid", 256'(rd_valid), 256'(0));
        check("rst_rd_data", 256'(rd_data), 256'(0));
    endtask

    // One clock cycle of stimulus; the model advances as the DUT should at the next edge.
    task automatic step(input logic a, input logic s, input logic ft, input logic te,
                        input logic [15:0] tpc, input logic [15:0] pcv,
                        input logic ren, input logic [2:0] ra);
        trace_entry_t e;
        logic hit_m;
        logic rd_ok;
        @(negedge clk);
        rst = 1'b0; arm = a; sample = s; force_trig = ft; trig_en = te;
        trig_pc = tpc; pc = pcv; rd_en = ren; rd_addr = ra;
        for (int i = 0; i < NUM_REGS; i++) gprc[i*REG_W +: REG_W] = 16'($urandom);
        psw  = 16'($urandom);
        inst = 16'($urandom);
        e.gprc = gprc; e.psw = psw; e.pc = pcv; e.inst = inst;
`ifdef SYSTEM_TRACE_TIMESTAMP_EN
        e.ts = mts;
        mts  = a ? 32'd0 : mts + 32'd1;
`endif
        rd_ok = ren && (mstate == 3);
        if (rd_ok) exp_q.push_back((int'(ra) < hist.size()) ? hist[ra] : '0);
        hit_m = ft || (te && s && (pcv == tpc));
        if (a) begin
            mstate = 1;
            hist.delete();
            if (s) hist.push_back(e);
        end else if (mstate == 1) begin
            if (s) push_hist(e);
            if (hit_m) begin
                if (POST_TRIG == 0) mstate = 3;
                else begin
                    mstate = 2;
                    mpost  = POST_TRIG;
                end
            end
        end else if (mstate == 2 && s) begin
            push_hist(e);
            mpost--;
            if (mpost == 0) mstate = 3;
        end
        @(posedge clk);
        #1;
        check("state", 256'(state), 256'(mstate));
        check("count", 256'(count), 256'(hist.size()));
        check("done", 256'(done), 256'(mstate == 3));
        check("rd_valid", 256'(rd_valid), 256'(rd_ok));
    endtask

    task automatic smp(input logic [15:0] pcv);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, pcv, 1'b0, 3'd0);
    endtask

    task automatic rd(input logic [2:0] ra);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, ra);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; sample = 1'b0; force_trig = 1'b0; trig_en = 1'b0;
        trig_pc = '0; rd_en = 1'b0; rd_addr = '0; gprc = '0; psw = '0; pc = '0; inst = '0;
        do_reset(2);

        // Idle ignores samples; reads outside DONE are not valid.
        for (int i = 0; i < 5; i++) smp(16'(16'h100 + i));
        rd(3'd0);

        // Forced trigger, two post samples, in-order readback and out-of-range read.
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0);
        smp(16'h10); smp(16'h12); smp(16'h14);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0);
        smp(16'h16); smp(16'h18);
        check("t2_state", 256'(state), 256'(3));
        check("t2_count", 256'(count), 256'(5));
        for (int i = 0; i < 6; i++) rd(3'(i));

        // PC-match trigger with wrap-around.
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h40, 16'h0, 1'b0, 3'd0);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 16'h40, 16'(16'h30 + 2 * i), 1'b0, 3'd0);
        check("t3_state", 256'(state), 256'(3));
        check("t3_count", 256'(count), 256'(8));
        for (int i = 0; i < 8; i++) rd(3'(i));

        // Arm wins over a coincident PC match.
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h40, 16'h40, 1'b0, 3'd0);
        check("t4_state", 256'(state), 256'(1));
        check("t4_count", 256'(count), 256'(1));

        // Reset during POST aborts; samples then ignored.
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0);
        check("t5_post", 256'(state), 256'(2));
        smp(16'h50);
        do_reset(1);
        for (int i = 0; i < 3; i++) smp(16'(16'h60 + i));

        // Random traffic.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1);
            end else begin
                step($urandom_range(0, 19) == 0,
                     1'($urandom_range(0, 1)),
                     $urandom_range(0, 29) == 0,
                     1'($urandom_range(0, 1)),
                     16'(16'h20 + 2 * $urandom_range(0, 7)),
                     16'(16'h20 + 2 * $urandom_range(0, 7)),
                     (mstate == 3) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0),
                     3'($urandom_range(0, 7)));
            end
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0);
        repeat (2) @(negedge clk);
        check("scoreboard_drain", 256'(exp_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
